// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// owner encoding for the in-flight tracking FIFO and the grant type.
package mem_port_arbiter_pkg;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   localparam logic [3:0]  BE_ALL     = 4'hf;
   localparam logic [31:0] WDATA_NONE = 32'h0000_0000;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_e;

   // Unlocked arbitration decision; an idle port pair defaults to the instruction side.
   function automatic gnt_e arb_pick(
      input logic ivalid,
      input logic dvalid,
      input gnt_e rr,
      input logic data_prio
   );
      gnt_e pick;
      if (ivalid && dvalid) begin
         pick = data_prio ? GNT_D : rr;
      end else if (dvalid) begin
         pick = GNT_D;
      end else begin
         pick = GNT_I;
      end
      return pick;
   endfunction

   function automatic logic gnt_owner(input gnt_e gnt);
      logic owner;
      if (gnt == GNT_D) begin
         owner = OWNER_D;
      end else begin
         owner = OWNER_I;
      end
      return owner;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_otx_fifo.sv
// One-bit-wide owner FIFO recording which port issued each in-flight transaction.
// Pointers carry an extra wrap bit so full and empty are distinguished without a counter.
module mem_port_arbiter_otx_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int C_OTX_SZX = 2
) (
   input  logic clk_i,
   input  logic resetb_i,
   input  logic clk_en_i,
   input  logic push_i,
   input  logic push_owner_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   localparam int                 DEPTH   = 2 ** C_OTX_SZX;
   localparam logic [C_OTX_SZX:0] DEPTH_W = (C_OTX_SZX + 1)'(DEPTH);
   localparam logic [C_OTX_SZX:0] PTR_ONE = (C_OTX_SZX + 1)'(1);

   logic [DEPTH-1:0]   mem_r;
   logic [C_OTX_SZX:0] wr_ptr_r;
   logic [C_OTX_SZX:0] rd_ptr_r;
   logic [C_OTX_SZX:0] count_s;
   logic               do_push_s;
   logic               do_pop_s;

   assign count_s   = wr_ptr_r - rd_ptr_r;
   assign full_o    = (count_s == DEPTH_W);
   assign empty_o   = (wr_ptr_r == rd_ptr_r);
   assign head_o    = mem_r[rd_ptr_r[C_OTX_SZX-1:0]];
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;

   // Owner storage and wrap pointers; a simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         mem_r    <= {DEPTH{OWNER_I}};
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (clk_en_i) begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[C_OTX_SZX-1:0]] <= push_owner_i;
            wr_ptr_r                       <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch and the data port.
// Requests are arbitrated combinationally; in-order responses are steered by the owner FIFO head.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int C_OTX_SZX   = 2,
   parameter int C_DATA_PRIO = 0
) (
   input  logic        clk_i,
   input  logic        resetb_i,
   input  logic        clk_en_i,

   output logic        ireqready_o,
   input  logic        ireqvalid_i,
   input  logic [1:0]  ireqhpl_i,
   input  logic [31:0] ireqaddr_i,
   input  logic        irspready_i,
   output logic        irspvalid_o,
   output logic        irsprerr_o,
   output logic [31:0] irspdata_o,

   output logic        dreqready_o,
   input  logic        dreqvalid_i,
   input  logic [1:0]  dreqhpl_i,
   input  logic [31:0] dreqaddr_i,
   input  logic        dreqwr_i,
   input  logic [3:0]  dreqbe_i,
   input  logic [31:0] dreqwdata_i,
   input  logic        drspready_i,
   output logic        drspvalid_o,
   output logic        drsprerr_o,
   output logic        drspwerr_o,
   output logic [31:0] drspdata_o,

   input  logic        mreqready_i,
   output logic        mreqvalid_o,
   output logic [1:0]  mreqhpl_o,
   output logic [31:0] mreqaddr_o,
   output logic        mreqwr_o,
   output logic [3:0]  mreqbe_o,
   output logic [31:0] mreqwdata_o,
   output logic        mrspready_o,
   input  logic        mrspvalid_i,
   input  logic        mrsprerr_i,
   input  logic        mrspwerr_i,
   input  logic [31:0] mrspdata_i
);

   localparam logic DATA_PRIO = (C_DATA_PRIO != 0);

   gnt_e gnt_s;
   gnt_e lock_gnt_r;
   gnt_e rr_r;
   logic lock_r;
   logic gnt_valid_s;
   logic contend_s;
   logic accept_s;
   logic pop_s;
   logic full_s;
   logic empty_s;
   logic head_s;

   // A stalled request keeps its grant so the payload cannot change under the memory side.
   always_comb begin
      gnt_s = GNT_I;
      if (lock_r) begin
         gnt_s = lock_gnt_r;
      end else begin
         gnt_s = arb_pick(ireqvalid_i, dreqvalid_i, rr_r, DATA_PRIO);
      end
   end

   // Request payload mux; instruction fetches are full-word reads.
   always_comb begin
      gnt_valid_s = 1'b0;
      mreqhpl_o   = 2'b00;
      mreqaddr_o  = 32'h0000_0000;
      mreqwr_o    = 1'b0;
      mreqbe_o    = BE_ALL;
      mreqwdata_o = WDATA_NONE;
      if (gnt_s == GNT_D) begin
         gnt_valid_s = dreqvalid_i;
         mreqhpl_o   = dreqhpl_i;
         mreqaddr_o  = dreqaddr_i;
         mreqwr_o    = dreqwr_i;
         mreqbe_o    = dreqbe_i;
         mreqwdata_o = dreqwdata_i;
      end else begin
         gnt_valid_s = ireqvalid_i;
         mreqhpl_o   = ireqhpl_i;
         mreqaddr_o  = ireqaddr_i;
         mreqwr_o    = 1'b0;
         mreqbe_o    = BE_ALL;
         mreqwdata_o = WDATA_NONE;
      end
   end

   assign contend_s   = ireqvalid_i && dreqvalid_i;
   assign mreqvalid_o = gnt_valid_s && !full_s;
   assign ireqready_o = (gnt_s == GNT_I) && mreqready_i && !full_s && clk_en_i;
   assign dreqready_o = (gnt_s == GNT_D) && mreqready_i && !full_s && clk_en_i;
   assign accept_s    = mreqvalid_o && mreqready_i && clk_en_i;

   // Response steering; the FIFO head names the port that owns the oldest transaction.
   assign mrspready_o = !empty_s && clk_en_i &&
                        ((head_s == OWNER_D) ? drspready_i : irspready_i);
   assign irspvalid_o = mrspvalid_i && !empty_s && (head_s == OWNER_I);
   assign drspvalid_o = mrspvalid_i && !empty_s && (head_s == OWNER_D);
   assign pop_s       = mrspvalid_i && mrspready_o;

   assign irsprerr_o  = mrsprerr_i;
   assign irspdata_o  = mrspdata_i;
   assign drsprerr_o  = mrsprerr_i;
   assign drspwerr_o  = mrspwerr_i;
   assign drspdata_o  = mrspdata_i;

   // Lock and round-robin state; the pointer only moves when a contended request is taken.
   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         lock_r     <= 1'b0;
         lock_gnt_r <= GNT_I;
         rr_r       <= GNT_I;
      end else if (clk_en_i) begin
         lock_r     <= mreqvalid_o && !mreqready_i;
         lock_gnt_r <= gnt_s;
         if (accept_s && contend_s) begin
            rr_r <= (gnt_s == GNT_D) ? GNT_I : GNT_D;
         end
      end
   end

   mem_port_arbiter_otx_fifo #(
      .C_OTX_SZX (C_OTX_SZX)
   ) u_otx_fifo (
      .clk_i        (clk_i),
      .resetb_i     (resetb_i),
      .clk_en_i     (clk_en_i),
      .push_i       (accept_s),
      .push_owner_i (gnt_owner(gnt_s)),
      .pop_i        (pop_s),
      .full_o       (full_s),
      .empty_o      (empty_s),
      .head_o       (head_s)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a randomized run,
// all checked against a queue-based model of the arbitration and response-routing rules.
module tb_mem_port_arbiter;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetb, ce;
   logic        iv, irr, dv, dwr, drr, mready, mrv, mrerr, mwerr;
   logic [1:0]  ihpl, dhpl;
   logic [31:0] ia, da, dwd, mrdata;
   logic [3:0]  dbe;
   logic        ireqready, irspvalid, irsprerr, dreqready, drspvalid, drsprerr, drspwerr;
   logic        mreqvalid, mreqwr, mrspready;
   logic [31:0] irspdata, drspdata, mreqaddr, mreqwdata;
   logic [1:0]  mreqhpl;
   logic [3:0]  mreqbe;

   mem_port_arbiter #(.C_OTX_SZX(2), .C_DATA_PRIO(0)) dut (
      .clk_i(clk), .resetb_i(resetb), .clk_en_i(ce),
      .ireqready_o(ireqready), .ireqvalid_i(iv), .ireqhpl_i(ihpl), .ireqaddr_i(ia),
      .irspready_i(irr), .irspvalid_o(irspvalid), .irsprerr_o(irsprerr), .irspdata_o(irspdata),
      .dreqready_o(dreqready), .dreqvalid_i(dv), .dreqhpl_i(dhpl), .dreqaddr_i(da),
      .dreqwr_i(dwr), .dreqbe_i(dbe), .dreqwdata_i(dwd), .drspready_i(drr),
      .drspvalid_o(drspvalid), .drsprerr_o(drsprerr), .drspwerr_o(drspwerr), .drspdata_o(drspdata),
      .mreqready_i(mready), .mreqvalid_o(mreqvalid), .mreqhpl_o(mreqhpl), .mreqaddr_o(mreqaddr),
      .mreqwr_o(mreqwr), .mreqbe_o(mreqbe), .mreqwdata_o(mreqwdata), .mrspready_o(mrspready),
      .mrspvalid_i(mrv), .mrsprerr_i(mrerr), .mrspwerr_i(mwerr), .mrspdata_i(mrdata)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: owners of in-flight transactions, a pending (shown, not taken) port,
   // and which port wins the next tie.
   bit owner_q[$];
   int pend;
   bit pref;
   bit e_g, e_mvalid, e_acc, e_pop, e_mrready;

   typedef struct {
      bit          iv, dv, dwr, mready;
      logic [3:0]  dbe;
      logic [31:0] ia, da;
      bit          exp_mvalid;
      logic [31:0] exp_addr;
      bit          exp_wr;
      logic [3:0]  exp_be;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      owner_q.delete();
      pend = -1;
      pref = 1'b0;
   endtask

   task automatic idle();
      iv = 1'b0; dv = 1'b0; dwr = 1'b0; dbe = 4'h0; dwd = 32'h0; ia = 32'h0; da = 32'h0;
      ihpl = 2'b00; dhpl = 2'b00; irr = 1'b0; drr = 1'b0; mready = 1'b0;
      mrv = 1'b0; mrerr = 1'b0; mwerr = 1'b0; mrdata = 32'h0; ce = 1'b1;
   endtask

   // Settle the current inputs, derive the expected outputs and compare.
   task automatic check_now();
      bit full, empty, head, gv;
      #4;
      if (!resetb) model_reset();
      full  = (owner_q.size() == DEPTH);
      empty = (owner_q.size() == 0);
      head  = empty ? 1'b0 : owner_q[0];
      if (pend >= 0)     e_g = pend[0];
      else if (iv && dv) e_g = pref;
      else               e_g = dv;
      gv         = e_g ? dv : iv;
      e_mvalid   = gv && !full;
      e_acc      = e_mvalid && mready && ce;
      e_mrready  = !empty && ce && (head ? drr : irr);
      e_pop      = mrv && e_mrready;
      chk("mreqvalid", {31'h0, mreqvalid}, {31'h0, e_mvalid});
      chk("mreqaddr", mreqaddr, e_g ? da : ia);
      chk("mreqhpl", {30'h0, mreqhpl}, {30'h0, (e_g ? dhpl : ihpl)});
      chk("mreqwr", {31'h0, mreqwr}, {31'h0, (e_g ? dwr : 1'b0)});
      chk("mreqbe", {28'h0, mreqbe}, {28'h0, (e_g ? dbe : 4'hf)});
      chk("mreqwdata", mreqwdata, e_g ? dwd : 32'h0);
      chk("ireqready", {31'h0, ireqready}, {31'h0, (!e_g && mready && !full && ce)});
      chk("dreqready", {31'h0, dreqready}, {31'h0, (e_g && mready && !full && ce)});
      chk("mrspready", {31'h0, mrspready}, {31'h0, e_mrready});
      chk("irspvalid", {31'h0, irspvalid}, {31'h0, (mrv && !empty && !head)});
      chk("drspvalid", {31'h0, drspvalid}, {31'h0, (mrv && !empty && head)});
      chk("irspdata", irspdata, mrdata);
      chk("drspdata", drspdata, mrdata);
      chk("rsperr", {29'h0, irsprerr, drsprerr, drspwerr}, {29'h0, mrerr, mrerr, mwerr});
   endtask

   task automatic tick();
      if (!resetb) begin
         model_reset();
      end else if (ce) begin
         if (e_pop) void'(owner_q.pop_front());
         if (e_acc) owner_q.push_back(e_g);
         pend = (e_mvalid && !mready) ? int'(e_g) : -1;
         if (e_acc && iv && dv) pref = !e_g;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc_i, acc_d;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h10, 32'h20, 1'b0, 32'h10, 1'b0, 4'hf};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h10, 32'h20, 1'b1, 32'h10, 1'b0, 4'hf};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h10, 32'h20, 1'b1, 32'h20, 1'b1, 4'h3};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 32'h40, 32'h80, 1'b1, 32'h40, 1'b0, 4'hf};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hc, 32'h40, 32'h84, 1'b1, 32'h84, 1'b0, 4'hc};

      idle();
      ce = 1'b0;
      resetb = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_now();
      chk("reset_be", {28'h0, mreqbe}, 32'hf);
      chk("reset_mvalid", {31'h0, mreqvalid}, 32'h0);
      tick();
      resetb = 1'b1;

      // Clock enable held low: grant mux is visible but no ready and no state change.
      for (int i = 0; i < 5; i++) begin
         idle();
         ce = 1'b0;
         iv = tbl[i].iv; dv = tbl[i].dv; dwr = tbl[i].dwr; dbe = tbl[i].dbe;
         ia = tbl[i].ia; da = tbl[i].da; mready = tbl[i].mready;
         check_now();
         chk("tbl_mvalid", {31'h0, mreqvalid}, {31'h0, tbl[i].exp_mvalid});
         chk("tbl_addr", mreqaddr, tbl[i].exp_addr);
         chk("tbl_wr", {31'h0, mreqwr}, {31'h0, tbl[i].exp_wr});
         chk("tbl_be", {28'h0, mreqbe}, {28'h0, tbl[i].exp_be});
         chk("tbl_readys_gated", {30'h0, ireqready, dreqready}, 32'h0);
         tick();
      end

      // Instruction-only fetch and its response.
      idle(); iv = 1'b1; ia = 32'h100; mready = 1'b1;
      check_now();
      chk("t1_addr", mreqaddr, 32'h100);
      chk("t1_ready", {31'h0, ireqready}, 32'h1);
      tick();
      idle(); mrv = 1'b1; mrdata = 32'h13; irr = 1'b1;
      check_now();
      chk("t1_irspvalid", {31'h0, irspvalid}, 32'h1);
      chk("t1_irspdata", irspdata, 32'h13);
      chk("t1_drspvalid", {31'h0, drspvalid}, 32'h0);
      tick();

      // Round-robin contention: I, D, I, D, then responses route in the same order.
      idle(); mready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         iv = 1'b1; dv = 1'b1; ia = 32'h200 + 32'(k); da = 32'h2000 + 32'(k);
         check_now();
         chk("t2_grant", mreqaddr, (k % 2 == 0) ? 32'h200 + 32'(k) : 32'h2000 + 32'(k));
         tick();
      end
      idle(); mrv = 1'b1; irr = 1'b1; drr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mrdata = 32'(k);
         check_now();
         chk("t2_irsp", {31'h0, irspvalid}, (k % 2 == 0) ? 32'h1 : 32'h0);
         chk("t2_drsp", {31'h0, drspvalid}, (k % 2 == 1) ? 32'h1 : 32'h0);
         tick();
      end

      // Lock: stalled data request is not preempted by a later instruction request.
      idle(); dv = 1'b1; da = 32'hD00; dwr = 1'b1; dbe = 4'h3;
      check_now();
      chk("t3_addr0", mreqaddr, 32'hD00);
      tick();
      for (int k = 0; k < 2; k++) begin
         iv = 1'b1; ia = 32'h300;
         check_now();
         chk("t3_addr_locked", mreqaddr, 32'hD00);
         chk("t3_iready", {31'h0, ireqready}, 32'h0);
         tick();
      end
      mready = 1'b1;
      check_now();
      chk("t3_release", {30'h0, ireqready, dreqready}, 32'h1);
      tick();
      dv = 1'b0;
      check_now();
      chk("t3_then_i", mreqaddr, 32'h300);
      tick();
      idle(); mrv = 1'b1; irr = 1'b1; drr = 1'b1;
      check_now(); tick();
      check_now(); tick();

      // Full: a pop in the same cycle does not unblock the fifth request.
      idle(); mready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         iv = 1'b1; ia = 32'h400 + 32'(4 * k);
         check_now(); tick();
      end
      ia = 32'h410;
      check_now();
      chk("t4_full_valid", {31'h0, mreqvalid}, 32'h0);
      chk("t4_full_ready", {31'h0, ireqready}, 32'h0);
      tick();
      mrv = 1'b1; irr = 1'b1;
      check_now();
      chk("t4_pop_same_cycle", {31'h0, ireqready}, 32'h0);
      tick();
      mrv = 1'b0;
      check_now();
      chk("t4_unblocked", {31'h0, ireqready}, 32'h1);
      tick();
      idle(); mrv = 1'b1; irr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_now(); tick();
      end

      // Response backpressure from the data port, then store error on release.
      idle(); dv = 1'b1; da = 32'h500; dwr = 1'b1; dbe = 4'hf; dwd = 32'hCAFE; mready = 1'b1;
      check_now();
      chk("t5_wdata", mreqwdata, 32'hCAFE);
      tick();
      idle(); mrv = 1'b1; mwerr = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check_now();
         chk("t5_hold", {30'h0, mrspready, drspvalid}, 32'h1);
         tick();
      end
      drr = 1'b1;
      check_now();
      chk("t5_release", {30'h0, mrspready, drspwerr}, 32'h3);
      tick();

      // Reset with two outstanding, then a stray response.
      idle(); mready = 1'b1; iv = 1'b1; ia = 32'h600;
      check_now(); tick();
      check_now(); tick();
      idle(); resetb = 1'b0;
      check_now(); tick();
      resetb = 1'b1; mrv = 1'b1; irr = 1'b1; drr = 1'b1;
      check_now();
      chk("t6_stray", {29'h0, mrspready, irspvalid, drspvalid}, 32'h0);
      tick();
      idle(); mready = 1'b1; iv = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ia = 32'h700 + 32'(k);
         check_now();
         chk("t6_capacity", {31'h0, ireqready}, (k < 4) ? 32'h1 : 32'h0);
         tick();
      end
      idle(); mrv = 1'b1; irr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_now(); tick();
      end

      // Randomized traffic; requesters hold their request until it is taken.
      idle();
      for (int n = 0; n < 2000; n++) begin
         if (!iv && $urandom_range(0, 2) != 0) begin
            iv = 1'b1; ia = $urandom; ihpl = 2'($urandom);
         end
         if (!dv && $urandom_range(0, 2) != 0) begin
            dv = 1'b1; da = $urandom; dhpl = 2'($urandom);
            dwr = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
         end
         mready = ($urandom_range(0, 3) != 0);
         mrv    = 1'($urandom);
         mrerr  = 1'($urandom);
         mwerr  = 1'($urandom);
         mrdata = $urandom;
         irr    = ($urandom_range(0, 3) != 0);
         drr    = ($urandom_range(0, 3) != 0);
         ce     = ($urandom_range(0, 7) != 0);
         check_now();
         acc_i = e_acc && !e_g;
         acc_d = e_acc && e_g;
         tick();
         if (acc_i) iv = 1'b0;
         if (acc_d) dv = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
